// File: rtl/lfsr_stream_if.sv
// rtl/lfsr_stream_if.sv - control and word-stream bundle for lfsr_stream
interface lfsr_stream_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 24
);
  logic [WIDTH-1:0] seed_in;
  logic             load_in;
  logic             en_in;
  logic             ready_in;
  logic             valid_out;
  logic [WIDTH-1:0] q_out;
  logic             bit_out;
  logic             wrap_out;
  logic [CNT_W-1:0] period_out;
  logic             period_valid_out;

  // Generator side: owns the stream outputs, receives control and backpressure
  modport master (
    input  seed_in, load_in, en_in, ready_in,
    output valid_out, q_out, bit_out, wrap_out, period_out, period_valid_out
  );

  // Consumer/controller side
  modport slave (
    output seed_in, load_in, en_in, ready_in,
    input  valid_out, q_out, bit_out, wrap_out, period_out, period_valid_out
  );
endinterface

// File: rtl/lfsr_stream.sv
// rtl/lfsr_stream.sv - parametrised Galois LFSR word source with ready/valid stream and period measurement
module lfsr_stream #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'h8005,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001,
  parameter int               CNT_W        = 24
) (
  input logic           clk_in,
  input logic           rst_in,
  lfsr_stream_if.master bus
);

  if (WIDTH < 3) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be >= 3");
  end
  if (TAPS[0] != 1'b1) begin : g_bad_taps
    $error("lfsr_stream: TAPS[0] must be 1");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_stream: STEP must be in 1..WIDTH");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("lfsr_stream: DEFAULT_SEED must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] q_adv;
  logic [WIDTH-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] period;
  logic             sat;
  logic             sat_inc;
  logic             valid;
  logic             wrap;
  logic             period_valid;
  logic             xfer;
  logic             hit_idle;
  logic             hit_run;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? TAPS : '0);
  endfunction

  // STEP chained single shifts, all within one cycle
  always_comb begin
    q_adv = q;
    for (int i = 0; i < STEP; i++) begin
      q_adv = shift1(q_adv);
    end
  end

  // A zero seed would lock the register at zero forever, so substitute the default
  assign load_val = (bus.seed_in == '0) ? DEFAULT_SEED : bus.seed_in;
  assign xfer     = valid & bus.ready_in;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  // sat marks that the counter has been pushed past all-ones, so any later period would be wrong
  assign sat_inc  = sat | (cnt == '1);
  assign hit_idle = (q == seed_reg) && (cnt != '0);
  assign hit_run  = (q_adv == seed_reg);

  // Stream FSM, LFSR state, word counter, wrap flag and period capture
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      q            <= DEFAULT_SEED;
      seed_reg     <= DEFAULT_SEED;
      cnt          <= '0;
      sat          <= 1'b0;
      valid        <= 1'b0;
      wrap         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (bus.load_in) begin
      state        <= PRIME;
      q            <= load_val;
      seed_reg     <= load_val;
      cnt          <= '0;
      sat          <= 1'b0;
      valid        <= 1'b0;
      wrap         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en_in) begin
            state <= RUN;
            valid <= 1'b1;
            wrap  <= hit_idle;
            if (hit_idle && !period_valid && !sat) begin
              period       <= cnt;
              period_valid <= 1'b1;
            end
          end
        end
        PRIME: begin
          state <= RUN;
          valid <= 1'b1;
          wrap  <= 1'b0;
        end
        RUN: begin
          if (xfer) begin
            q   <= q_adv;
            cnt <= cnt_inc;
            sat <= sat_inc;
            if (bus.en_in) begin
              wrap <= hit_run;
              if (hit_run && !period_valid && !sat_inc) begin
                period       <= cnt_inc;
                period_valid <= 1'b1;
              end
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              wrap  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid_out        = valid;
  assign bus.q_out            = q;
  assign bus.bit_out          = q[WIDTH-1];
  assign bus.wrap_out         = wrap;
  assign bus.period_out       = period;
  assign bus.period_valid_out = period_valid;

endmodule
